// File: rtl/vend_controller.sv
// N-product vending transaction engine: coin credit, price/stock check, dispense and greedy change.
// Build option: define VEND_DISCOUNT_EN to enable session-count discount pricing.
module vend_controller #(
   parameter int unsigned NUM_PRODUCTS       = 8,
   parameter int unsigned STOCK_W            = 5,
   parameter int unsigned INIT_STOCK         = 10,
   parameter int unsigned LOW_THRESHOLD      = 5,
   parameter int unsigned CREDIT_W           = 16,
   parameter int unsigned PRICE_W            = 8,
   parameter int unsigned DISCOUNT_THRESHOLD = 3,
   localparam int unsigned IDW = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            coin_valid,
   input  logic [1:0]                      coin,
   output logic                            coin_reject,
   input  logic                            select_valid,
   input  logic [IDW-1:0]                  select_id,
   input  logic                            cancel,
   input  logic [NUM_PRODUCTS*PRICE_W-1:0] price_table,
   input  logic                            restock_valid,
   input  logic [IDW-1:0]                  restock_id,
   output logic                            dispense_valid,
   output logic [IDW-1:0]                  dispense_id,
   input  logic                            dispense_ready,
   output logic                            change_valid,
   output logic [1:0]                      change_coin,
   input  logic                            change_ready,
   output logic [CREDIT_W-1:0]             credit,
   output logic [STOCK_W-1:0]              stock,
   output logic                            low_stock,
   output logic [2:0]                      state,
   output logic                            error,
   output logic [1:0]                      error_code
);

   // Session count only needs to resolve "reached the threshold", so it saturates there.
   localparam int unsigned SESS_W =
      (DISCOUNT_THRESHOLD > 0) ? $clog2(DISCOUNT_THRESHOLD + 1) : 1;

   localparam logic [1:0] ErrBadId   = 2'd1;
   localparam logic [1:0] ErrSoldOut = 2'd2;
   localparam logic [1:0] ErrNoFunds = 2'd3;

   typedef enum logic [2:0] {
      StIdle     = 3'd0,
      StCredit   = 3'd1,
      StCheck    = 3'd2,
      StDispense = 3'd3,
      StChange   = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CREDIT_W-1:0]  credit_q, credit_d;
   logic [IDW-1:0]       sel_id_q, sel_id_d;
   logic [SESS_W-1:0]    session_q, session_d;
   logic [STOCK_W-1:0]   stock_q [NUM_PRODUCTS];
   logic [STOCK_W-1:0]   stock_d [NUM_PRODUCTS];
   logic                 coin_reject_q, coin_reject_d;
   logic                 error_q, error_d;
   logic [1:0]           error_code_q, error_code_d;
   logic                 dispense_valid_q, dispense_valid_d;
   logic [IDW-1:0]       dispense_id_q, dispense_id_d;
   logic                 change_valid_q, change_valid_d;
   logic [1:0]           change_coin_q, change_coin_d;

   logic [CREDIT_W:0]    coin_sum;
   logic                 coin_ovf;
   logic [STOCK_W-1:0]   sel_stock;
   logic [PRICE_W-1:0]   sel_price;
   logic [PRICE_W-1:0]   charged_price;

   function automatic logic [5:0] coin_value(input logic [1:0] c);
      logic [5:0] v;
      case (c)
         2'b00:   v = 6'd5;
         2'b01:   v = 6'd10;
         2'b10:   v = 6'd20;
         default: v = 6'd50;
      endcase
      return v;
   endfunction

   // Largest coin not exceeding the amount still owed.
   function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
      logic [1:0] g;
      if (c >= CREDIT_W'(50)) begin
         g = 2'b11;
      end else if (c >= CREDIT_W'(20)) begin
         g = 2'b10;
      end else if (c >= CREDIT_W'(10)) begin
         g = 2'b01;
      end else begin
         g = 2'b00;
      end
      return g;
   endfunction

   assign coin_sum = {1'b0, credit_q} + (CREDIT_W+1)'(coin_value(coin));
   assign coin_ovf = coin_sum[CREDIT_W];

   // Table lookups for the latched selection and the live select_id.
   always_comb begin
      sel_stock = '0;
      sel_price = '0;
      stock     = '0;
      for (int i = 0; i < NUM_PRODUCTS; i++) begin
         if (sel_id_q == IDW'(i)) begin
            sel_stock = stock_q[i];
            sel_price = price_table[i*PRICE_W +: PRICE_W];
         end
         if (select_id == IDW'(i)) begin
            stock = stock_q[i];
         end
      end
   end

`ifdef VEND_DISCOUNT_EN
   logic [PRICE_W+3:0] price_ext;
   logic [PRICE_W+3:0] price_90;
   logic [PRICE_W-1:0] disc_price;

   // 90% of list price, rounded down to the 5-unit coin grid.
   always_comb begin
      price_ext  = (PRICE_W+4)'(sel_price);
      price_90   = (price_ext * (PRICE_W+4)'(9)) / (PRICE_W+4)'(10);
      disc_price = PRICE_W'(price_90 - (price_90 % (PRICE_W+4)'(5)));
   end

   assign charged_price = (session_q >= SESS_W'(DISCOUNT_THRESHOLD)) ? disc_price : sel_price;
`else
   logic unused_session;

   assign charged_price  = sel_price;
   assign unused_session = ^session_q;
`endif

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= StIdle;
         credit_q         <= '0;
         sel_id_q         <= '0;
         session_q        <= '0;
         coin_reject_q    <= 1'b0;
         error_q          <= 1'b0;
         error_code_q     <= 2'd0;
         dispense_valid_q <= 1'b0;
         dispense_id_q    <= '0;
         change_valid_q   <= 1'b0;
         change_coin_q    <= 2'b00;
         for (int i = 0; i < NUM_PRODUCTS; i++) begin
            stock_q[i] <= STOCK_W'(INIT_STOCK);
         end
      end else begin
         state_q          <= state_d;
         credit_q         <= credit_d;
         sel_id_q         <= sel_id_d;
         session_q        <= session_d;
         coin_reject_q    <= coin_reject_d;
         error_q          <= error_d;
         error_code_q     <= error_code_d;
         dispense_valid_q <= dispense_valid_d;
         dispense_id_q    <= dispense_id_d;
         change_valid_q   <= change_valid_d;
         change_coin_q    <= change_coin_d;
         stock_q          <= stock_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      credit_d      = credit_q;
      sel_id_d      = sel_id_q;
      session_d     = session_q;
      stock_d       = stock_q;
      coin_reject_d = 1'b0;
      error_d       = 1'b0;
      error_code_d  = error_code_q;

      case (state_q)
         StIdle: begin
            if (coin_valid) begin
               credit_d = coin_sum[CREDIT_W-1:0];
               state_d  = StCredit;
            end
            if (restock_valid) begin
               for (int i = 0; i < NUM_PRODUCTS; i++) begin
                  if (restock_id == IDW'(i)) begin
                     stock_d[i] = STOCK_W'(INIT_STOCK);
                  end
               end
            end
         end

         // Coin beats cancel beats select; losers are dropped, not queued.
         StCredit: begin
            if (coin_valid) begin
               if (coin_ovf) begin
                  coin_reject_d = 1'b1;
               end else begin
                  credit_d = coin_sum[CREDIT_W-1:0];
               end
            end else if (cancel) begin
               state_d = (credit_q == '0) ? StIdle : StChange;
            end else if (select_valid) begin
               sel_id_d = select_id;
               state_d  = StCheck;
            end
         end

         StCheck: begin
            coin_reject_d = coin_valid;
            if (32'(sel_id_q) >= NUM_PRODUCTS) begin
               error_d      = 1'b1;
               error_code_d = ErrBadId;
               state_d      = StCredit;
            end else if (sel_stock == '0) begin
               error_d      = 1'b1;
               error_code_d = ErrSoldOut;
               state_d      = StCredit;
            end else if (credit_q < CREDIT_W'(charged_price)) begin
               error_d      = 1'b1;
               error_code_d = ErrNoFunds;
               state_d      = StCredit;
            end else begin
               credit_d = credit_q - CREDIT_W'(charged_price);
               for (int i = 0; i < NUM_PRODUCTS; i++) begin
                  if (sel_id_q == IDW'(i)) begin
                     stock_d[i] = stock_q[i] - STOCK_W'(1);
                  end
               end
               if (session_q < SESS_W'(DISCOUNT_THRESHOLD)) begin
                  session_d = session_q + SESS_W'(1);
               end
               state_d = StDispense;
            end
         end

         StDispense: begin
            coin_reject_d = coin_valid;
            if (dispense_valid_q && dispense_ready) begin
               state_d = (credit_q != '0) ? StChange : StIdle;
            end
         end

         // A residue below the smallest coin cannot be paid out and is dropped.
         StChange: begin
            coin_reject_d = coin_valid;
            if (credit_q < CREDIT_W'(5)) begin
               credit_d = '0;
               state_d  = StIdle;
            end else if (change_valid_q && change_ready) begin
               credit_d = credit_q - CREDIT_W'(coin_value(change_coin_q));
               if (credit_d < CREDIT_W'(5)) begin
                  credit_d = '0;
                  state_d  = StIdle;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StIdle) begin
         session_d = '0;
      end
   end

   // Handshake payloads are derived from next state so they register alongside it.
   always_comb begin
      dispense_valid_d = (state_d == StDispense);
      dispense_id_d    = dispense_valid_d ? sel_id_d : dispense_id_q;
      change_valid_d   = (state_d == StChange) && (credit_d >= CREDIT_W'(5));
      change_coin_d    = change_valid_d ? greedy_coin(credit_d) : change_coin_q;
      low_stock        = (32'(stock) < LOW_THRESHOLD);
   end

   assign coin_reject    = coin_reject_q;
   assign error          = error_q;
   assign error_code     = error_code_q;
   assign dispense_valid = dispense_valid_q;
   assign dispense_id    = dispense_id_q;
   assign change_valid   = change_valid_q;
   assign change_coin    = change_coin_q;
   assign credit         = credit_q;
   assign state          = state_q;

endmodule

// File: tb/tb_vend_controller.sv
// Bench for vend_controller: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_vend_controller;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        coin_valid = 1'b0;
   logic [1:0]  coin = 2'b00;
   logic        coin_reject;
   logic        select_valid = 1'b0;
   logic [2:0]  select_id = 3'd0;
   logic        cancel = 1'b0;
   logic [63:0] price_table = '0;
   logic        restock_valid = 1'b0;
   logic [2:0]  restock_id = 3'd0;
   logic        dispense_valid;
   logic [2:0]  dispense_id;
   logic        dispense_ready = 1'b0;
   logic        change_valid;
   logic [1:0]  change_coin;
   logic        change_ready = 1'b0;
   logic [15:0] credit;
   logic [4:0]  stock;
   logic        low_stock;
   logic [2:0]  state;
   logic        error;
   logic [1:0]  error_code;

   vend_controller dut (
      .clock          (clock),
      .reset          (reset),
      .coin_valid     (coin_valid),
      .coin           (coin),
      .coin_reject    (coin_reject),
      .select_valid   (select_valid),
      .select_id      (select_id),
      .cancel         (cancel),
      .price_table    (price_table),
      .restock_valid  (restock_valid),
      .restock_id     (restock_id),
      .dispense_valid (dispense_valid),
      .dispense_id    (dispense_id),
      .dispense_ready (dispense_ready),
      .change_valid   (change_valid),
      .change_coin    (change_coin),
      .change_ready   (change_ready),
      .credit         (credit),
      .stock          (stock),
      .low_stock      (low_stock),
      .state          (state),
      .error          (error),
      .error_code     (error_code)
   );

   always #5 clock = ~clock;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int prices [8] = '{15, 40, 5, 25, 50, 35, 100, 255};

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
      end
   endtask

   // Reference model: phase numbers are the externally visible state codes.
   int m_phase = 0;
   int m_credit = 0;
   int m_sess = 0;
   int m_sel = 0;
   int m_disp_id = 0;
   int m_code = 0;
   int m_rej = 0;
   int m_err = 0;
   int m_stock [8] = '{10, 10, 10, 10, 10, 10, 10, 10};
   int m_coins [$];

   function automatic int coin_val(input int c);
      case (c)
         0:       return 5;
         1:       return 10;
         2:       return 20;
         default: return 50;
      endcase
   endfunction

   // Pre-compute the whole greedy payout list for the current credit.
   function automatic void plan_change();
      int c;
      m_coins.delete();
      c = m_credit;
      while (c >= 5) begin
         if (c >= 50) begin m_coins.push_back(3); c -= 50; end
         else if (c >= 20) begin m_coins.push_back(2); c -= 20; end
         else if (c >= 10) begin m_coins.push_back(1); c -= 10; end
         else begin m_coins.push_back(0); c -= 5; end
      end
   endfunction

   function automatic int charge_for(input int id);
      int p;
      p = prices[id];
`ifdef VEND_DISCOUNT_EN
      if (m_sess >= 3) p = ((p * 9) / 10) / 5 * 5;
`endif
      return p;
   endfunction

   always @(posedge clock) begin
      int val;
      int price;
      cyc++;
      if (reset) begin
         m_phase = 0; m_credit = 0; m_sess = 0; m_sel = 0; m_disp_id = 0;
         m_code = 0; m_rej = 0; m_err = 0;
         for (int i = 0; i < 8; i++) m_stock[i] = 10;
         m_coins.delete();
      end else begin
         val   = coin_val(int'(coin));
         m_rej = 0;
         m_err = 0;
         case (m_phase)
            0: begin
               if (coin_valid) begin m_credit += val; m_phase = 1; end
               if (restock_valid) m_stock[restock_id] = 10;
            end
            1: begin
               if (coin_valid) begin
                  if (m_credit + val > 65535) m_rej = 1;
                  else m_credit += val;
               end else if (cancel) begin
                  if (m_credit == 0) m_phase = 0;
                  else begin plan_change(); m_phase = 4; end
               end else if (select_valid) begin
                  m_sel = int'(select_id);
                  m_phase = 2;
               end
            end
            2: begin
               m_rej = int'(coin_valid);
               price = charge_for(m_sel);
               if (m_stock[m_sel] == 0) begin m_err = 1; m_code = 2; m_phase = 1; end
               else if (m_credit < price) begin m_err = 1; m_code = 3; m_phase = 1; end
               else begin
                  m_credit -= price;
                  m_stock[m_sel]--;
                  m_sess++;
                  m_disp_id = m_sel;
                  m_phase = 3;
               end
            end
            3: begin
               m_rej = int'(coin_valid);
               if (dispense_ready) begin
                  if (m_credit > 0) begin plan_change(); m_phase = 4; end
                  else m_phase = 0;
               end
            end
            default: begin
               m_rej = int'(coin_valid);
               if (m_coins.size() == 0) begin
                  m_credit = 0; m_phase = 0;
               end else if (change_ready) begin
                  m_credit -= coin_val(m_coins.pop_front());
                  if (m_coins.size() == 0) begin m_credit = 0; m_phase = 0; end
               end
            end
         endcase
         if (m_phase == 0) m_sess = 0;
      end
   end

   // Single compare process, sampled mid-cycle.
   always @(negedge clock) begin
      chk("state", int'(state), m_phase);
      chk("credit", int'(credit), m_credit);
      chk("coin_reject", int'(coin_reject), m_rej);
      chk("error", int'(error), m_err);
      chk("error_code", int'(error_code), m_code);
      chk("dispense_valid", int'(dispense_valid), int'(m_phase == 3));
      if (m_phase == 3) chk("dispense_id", int'(dispense_id), m_disp_id);
      chk("change_valid", int'(change_valid), int'(m_phase == 4 && m_coins.size() > 0));
      if (m_phase == 4 && m_coins.size() > 0) chk("change_coin", int'(change_coin), m_coins[0]);
      chk("stock", int'(stock), m_stock[select_id]);
      chk("low_stock", int'(low_stock), int'(m_stock[select_id] < 5));
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic put_coin(input int c);
      coin_valid = 1'b1;
      coin = 2'(c);
      tick();
      coin_valid = 1'b0;
   endtask

   task automatic pick(input int id);
      select_valid = 1'b1;
      select_id = 3'(id);
      tick();
      select_valid = 1'b0;
   endtask

   initial begin
      int got [3];
      int seq [5] = '{0, 0, 1, 2, 3};
      for (int i = 0; i < 8; i++) price_table[i*8 +: 8] = 8'(prices[i]);

      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
      tick();
      chk("rst_state", int'(state), 0);
      chk("rst_credit", int'(credit), 0);
      chk("rst_dispense_valid", int'(dispense_valid), 0);
      chk("rst_change_valid", int'(change_valid), 0);
      chk("rst_error", int'(error), 0);
      chk("rst_error_code", int'(error_code), 0);
      chk("rst_dispense_id", int'(dispense_id), 0);
      chk("rst_change_coin", int'(change_coin), 0);
      select_id = 3'd3;
      #1 chk("rst_stock3", int'(stock), 10);

      // 5+5+10+20+50
      for (int i = 0; i < 5; i++) put_coin(seq[i]);
      chk("coins_credit", int'(credit), 90);
      chk("coins_state", int'(state), 1);
      chk("coins_no_reject", int'(coin_reject), 0);

      // Buy product 3 (25): dispense two cycles after select, then change 50,10,5.
      dispense_ready = 1'b1;
      pick(3);
      chk("buy_check_state", int'(state), 2);
      tick();
      chk("buy_dispense_valid", int'(dispense_valid), 1);
      chk("buy_dispense_id", int'(dispense_id), 3);
      chk("buy_credit_after", int'(credit), 65);
      #1 chk("buy_stock3", int'(stock), 9);
      tick();
      dispense_ready = 1'b0;
      chk("chg_valid", int'(change_valid), 1);
      change_ready = 1'b1;
      got[0] = int'(change_coin);
      tick();
      got[1] = int'(change_coin);
      tick();
      got[2] = int'(change_coin);
      tick();
      change_ready = 1'b0;
      chk("chg_coin0", got[0], 3);
      chk("chg_coin1", got[1], 1);
      chk("chg_coin2", got[2], 0);
      chk("chg_done_state", int'(state), 0);
      chk("chg_done_credit", int'(credit), 0);

      // Insufficient funds.
      put_coin(1);
      pick(3);
      tick();
      chk("nofunds_error", int'(error), 1);
      chk("nofunds_code", int'(error_code), 3);
      chk("nofunds_credit", int'(credit), 10);
      chk("nofunds_state", int'(state), 1);
      tick();
      chk("nofunds_pulse_end", int'(error), 0);
      chk("nofunds_code_held", int'(error_code), 3);

      // Coin and select together: coin wins, select dropped.
      coin_valid = 1'b1; coin = 2'd0; select_valid = 1'b1; select_id = 3'd2;
      tick();
      coin_valid = 1'b0; select_valid = 1'b0;
      chk("coinsel_credit", int'(credit), 15);
      chk("coinsel_state", int'(state), 1);
      tick();
      chk("coinsel_not_queued", int'(state), 1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      change_ready = 1'b1;
      tick(); tick(); tick();
      change_ready = 1'b0;
      chk("cancel_idle", int'(state), 0);

      // Drain product 2 (price 5) to sold out.
      dispense_ready = 1'b1;
      for (int s = 0; s < 10; s++) begin
         put_coin(0);
         pick(2);
         tick();
         tick();
      end
      dispense_ready = 1'b0;
      select_id = 3'd2;
      #1 chk("drain_stock2", int'(stock), 0);
      chk("drain_low", int'(low_stock), 1);
      put_coin(0);
      pick(2);
      tick();
      chk("soldout_error", int'(error), 1);
      chk("soldout_code", int'(error_code), 2);
      chk("soldout_credit", int'(credit), 5);

      // Stalled dispense of product 5 (35), with a coin arriving mid-stall.
      put_coin(1);
      put_coin(2);
      pick(5);
      tick();
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", int'(dispense_valid), 1);
         chk("stall_id", int'(dispense_id), 5);
         coin_valid = (k == 1);
         coin = 2'd3;
         tick();
         if (k == 1) begin
            chk("stall_coin_reject", int'(coin_reject), 1);
            chk("stall_credit", int'(credit), 0);
         end
      end
      coin_valid = 1'b0;
      dispense_ready = 1'b1;
      tick();
      dispense_ready = 1'b0;
      chk("stall_done_state", int'(state), 0);

      restock_valid = 1'b1; restock_id = 3'd2; select_id = 3'd2;
      tick();
      restock_valid = 1'b0;
      #1 chk("restock_stock2", int'(stock), 10);
      chk("restock_low", int'(low_stock), 0);

      // Fill credit to the top of the 16-bit range.
      for (int i = 0; i < 1310; i++) put_coin(3);
      chk("max_fill_credit", int'(credit), 65500);
      put_coin(3);
      chk("max_reject50", int'(coin_reject), 1);
      chk("max_credit_held", int'(credit), 65500);
      put_coin(2); put_coin(1); put_coin(0);
      chk("max_credit_full", int'(credit), 65535);
      put_coin(0);
      chk("max_reject5", int'(coin_reject), 1);

      // Reset during payout.
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      change_ready = 1'b1;
      tick(); tick(); tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      change_ready = 1'b0;
      chk("midchg_rst_state", int'(state), 0);
      chk("midchg_rst_credit", int'(credit), 0);
      chk("midchg_rst_change_valid", int'(change_valid), 0);

      // Four purchases of product 1 (40); each is its own session since change returns to idle.
      for (int s = 0; s < 4; s++) begin
         put_coin(3);
         pick(1);
         tick();
         if (s == 3) chk("fourth_charge", 50 - int'(credit), 40);
         dispense_ready = 1'b1;
         change_ready = 1'b1;
         tick(); tick(); tick();
         dispense_ready = 1'b0;
         change_ready = 1'b0;
         chk("session_idle", int'(state), 0);
      end

      for (int n = 0; n < 5000; n++) begin
         reset          = ($urandom_range(0, 299) == 0);
         coin_valid     = ($urandom_range(0, 99) < 30);
         coin           = 2'($urandom_range(0, 3));
         select_valid   = ($urandom_range(0, 99) < 25);
         select_id      = 3'($urandom_range(0, 7));
         cancel         = ($urandom_range(0, 99) < 4);
         restock_valid  = ($urandom_range(0, 99) < 5);
         restock_id     = 3'($urandom_range(0, 7));
         dispense_ready = ($urandom_range(0, 99) < 60);
         change_ready   = ($urandom_range(0, 99) < 60);
         tick();
      end

      reset = 1'b0; coin_valid = 1'b0; select_valid = 1'b0; cancel = 1'b0;
      restock_valid = 1'b0; dispense_ready = 1'b0; change_ready = 1'b0;
      tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
